lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Load/store unit between the RV32I execute stage and the data-memory port of the memory interface. It accepts one load/store request at a time and checks alignment. It generates a word-aligned address, byte enables and lane-replicated store data, and waits out the memory read latency. It returns sign- or zero-extended load data to writeback and stalls the pipeline while busy.

Parameters:
B_WIDTH, 32, data/address width; B_WIDTH/8 byte lanes
MEM_LATENCY, 1, cycles from mem_read_en to valid mem_rdata (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset (synchronous, active-high)
req_valid  in  1  execute stage presents a load/store
req_ready  out  1  LSU can accept (state IDLE)
req_is_store  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  in  B_WIDTH  effective byte address
req_wdata  in  B_WIDTH  store data (rs2)
req_rd  in  5  load destination register
resp_valid  out  1  one-cycle completion pulse
resp_rd  out  5  destination register (0 for stores/errors)
resp_data  out  B_WIDTH  extended load data (0 for stores/errors)
resp_err  out  1  misaligned address or illegal funct3
stall  out  1  pipeline hold: state != IDLE
mem_addr  out  B_WIDTH  word-aligned address {addr[B_WIDTH-1:2],2'b00}
mem_read_en  out  1  read strobe
mem_write_en  out  1  write strobe
write_byte_en  out  B_WIDTH/8  store byte lanes
mem_wdata  out  B_WIDTH  lane-replicated store data
mem_rdata  in  B_WIDTH  read data from the data memory

Behaviour:
- The clock port is clk and the reset port is rst. The design uses one clock. Reset is synchronous and active-high.
- Reset: state IDLE. All outputs are 0 except req_ready=1. Reset mid-operation aborts the operation: strobes drop at the reset edge and no resp_valid is issued.
- FSM states: IDLE, ACCESS, WAIT, RESP. Transitions:
  - IDLE: on req_valid (handshake at edge T), latch the request.
    - Error (half with addr[0]!=0, word with addr[1:0]!=0, funct3 not in {000,001,010,100,101} for loads or {000,001,010} for stores) -> RESP with resp_err=1. No memory strobes.
    - Otherwise -> ACCESS.
  - ACCESS: exactly one cycle. mem_addr is valid. A store asserts mem_write_en, write_byte_en and mem_wdata, then goes to RESP. A load asserts mem_read_en, then goes to WAIT.
  - WAIT: lasts MEM_LATENCY cycles (down-counter). mem_addr is held. mem_rdata is registered on the last WAIT cycle. Then -> RESP.
  - RESP: resp_valid=1 for one cycle, then -> IDLE. req_ready=0.
- Latency from accept edge to resp_valid: store 2 cycles; load 2+MEM_LATENCY cycles; error 1 cycle.
- Throughput: no overlap. A new request is accepted only in IDLE. req_ready is combinational on state.
- Store lanes:
  - SB: write_byte_en = 4'b0001 << addr[1:0]; mem_wdata = wdata[7:0] replicated x4.
  - SH: write_byte_en = 4'b0011 << {addr[1],1'b0}; mem_wdata = wdata[15:0] replicated x2.
  - SW: write_byte_en = 4'b1111; mem_wdata = wdata.
- Load extract: shift mem_rdata right by addr[1:0]*8. LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW passes through.
- Outside ACCESS, mem_read_en, mem_write_en, write_byte_en and mem_wdata are 0. mem_addr is 0 in IDLE and RESP.
- All outputs except req_ready and stall are registered.

Decomposition:
- lsu_pkg:
  - funct3 localparams: F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - State enum lsu_state_t.
  - Function is_misaligned(funct3, addr[1:0]).
- Sub-module lsu_align: purely combinational, containing store lane/byte-enable generation and the load shift/extend. It is instantiated once in lsu_ctrl and is unit-testable on its own.

Test Plan:
- SW addr=0x0000_0104, wdata=0xDEADBEEF. Required response: ACCESS cycle shows mem_addr=0x104, write_byte_en=4'b1111, mem_wdata=0xDEADBEEF, mem_write_en=1 for exactly one cycle. resp_valid arrives 2 cycles after accept with resp_err=0.
- SB addr=0x103, wdata=0x000000A5. Required response: write_byte_en=4'b1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100.
- LB vs LBU at addr=0x102, mem_rdata=0x1280_3456, MEM_LATENCY=1. Required response: LB gives resp_data=0xFFFFFF80; LBU gives 0x00000080. resp_valid arrives 3 cycles after accept with the correct resp_rd.
- LH at addr=0x101. Required response: resp_err=1 and resp_valid one cycle after accept. No mem_read_en pulse. resp_data=0.
- Back-to-back req_valid held high. Required response: the second request is accepted only after RESP, and stall is high throughout. Repeat the load with MEM_LATENCY=3: resp_valid arrives 5 cycles after accept.
- rst asserted during WAIT of a load. Required response: next cycle state is IDLE, req_ready=1, all strobes 0, and no resp_valid is issued.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I funct3 encodings for loads and stores
//   - lsu_state_t: controller FSM states
//   - lsu_req_t:   request fields held for the duration of an access
//   - is_misaligned / is_illegal: request error classification
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } lsu_state_t;

    typedef struct packed {
        logic       is_store;
        logic [2:0] funct3;
        logic [1:0] off;
        logic [4:0] rd;
    } lsu_req_t;

    // Halves must be 2-byte aligned, words 4-byte aligned; bytes never fault.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        case (funct3)
            F3_H, F3_HU: mis = addr_lo[0];
            F3_W:        mis = (addr_lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Stores have no unsigned variants, so BU/HU encodings are illegal for them.
    function automatic logic is_illegal(input logic is_store, input logic [2:0] funct3);
        logic ok;
        if (is_store) ok = funct3 inside {F3_B, F3_H, F3_W};
        else          ok = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        return !ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for the load/store unit.
//   funct3   : RV32I access size/sign
//   addr_off : byte offset within the word
//   wdata    : store source data (rs2)
//   rdata    : raw word read from memory
//   byte_en  : store byte lanes
//   st_data  : store data replicated across lanes
//   ld_data  : load data shifted down and sign/zero-extended
module lsu_align
    import lsu_pkg::*;
#(
    parameter int B_WIDTH = 32
) (
    input  logic [2:0]           funct3,
    input  logic [1:0]           addr_off,
    input  logic [B_WIDTH-1:0]   wdata,
    input  logic [B_WIDTH-1:0]   rdata,
    output logic [B_WIDTH/8-1:0] byte_en,
    output logic [B_WIDTH-1:0]   st_data,
    output logic [B_WIDTH-1:0]   ld_data
);

    localparam int NB = B_WIDTH / 8;

    logic [B_WIDTH-1:0] shifted;

    // Replicating the data means memory only has to honour byte_en; it never
    // needs to know the offset.
    always_comb begin
        byte_en = '0;
        st_data = '0;
        case (funct3)
            F3_B: begin
                byte_en = NB'(1) << addr_off;
                for (int i = 0; i < NB; i++) st_data[i*8 +: 8] = wdata[7:0];
            end
            F3_H: begin
                byte_en = NB'(3) << {addr_off[1], 1'b0};
                for (int i = 0; i < NB; i++) st_data[i*8 +: 8] = wdata[(i%2)*8 +: 8];
            end
            F3_W: begin
                byte_en = '1;
                st_data = wdata;
            end
            default: ;
        endcase
    end

    assign shifted = rdata >> {addr_off, 3'b000};

    always_comb begin
        case (funct3)
            F3_B:    ld_data = {{(B_WIDTH-8){shifted[7]}}, shifted[7:0]};
            F3_BU:   ld_data = {{(B_WIDTH-8){1'b0}}, shifted[7:0]};
            F3_H:    ld_data = {{(B_WIDTH-16){shifted[15]}}, shifted[15:0]};
            F3_HU:   ld_data = {{(B_WIDTH-16){1'b0}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller between execute and the
// data-memory port.
//   req_*   : request from execute; accepted in IDLE (req_ready)
//   resp_*  : one-cycle completion to writeback (rd/data zero for stores/errors)
//   stall   : pipeline hold while an access is in flight
//   mem_*   : word-aligned memory port; strobes only in ACCESS
// Every output other than req_ready/stall is a flop loaded on the edge that
// enters the state it belongs to.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int B_WIDTH     = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_is_store,
    input  logic [2:0]           req_funct3,
    input  logic [B_WIDTH-1:0]   req_addr,
    input  logic [B_WIDTH-1:0]   req_wdata,
    input  logic [4:0]           req_rd,
    output logic                 resp_valid,
    output logic [4:0]           resp_rd,
    output logic [B_WIDTH-1:0]   resp_data,
    output logic                 resp_err,
    output logic                 stall,
    output logic [B_WIDTH-1:0]   mem_addr,
    output logic                 mem_read_en,
    output logic                 mem_write_en,
    output logic [B_WIDTH/8-1:0] write_byte_en,
    output logic [B_WIDTH-1:0]   mem_wdata,
    input  logic [B_WIDTH-1:0]   mem_rdata
);

    localparam int NB = B_WIDTH / 8;
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    lsu_state_t    state, state_next;
    lsu_req_t      lat_req;
    logic [CW-1:0] wait_cnt;
    logic          req_err;

    logic [2:0]         al_f3;
    logic [1:0]         al_off;
    logic [NB-1:0]      al_be;
    logic [B_WIDTH-1:0] al_wdata, al_ldata;

    logic               resp_valid_d, resp_err_d, mem_read_en_d, mem_write_en_d;
    logic [4:0]         resp_rd_d;
    logic [B_WIDTH-1:0] resp_data_d, mem_addr_d, mem_wdata_d;
    logic [NB-1:0]      write_byte_en_d;

    assign req_ready = (state == IDLE);
    assign stall     = (state != IDLE);
    assign req_err   = is_illegal(req_is_store, req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);

    // Store lanes are built from the live request on the accept edge; load
    // extraction happens late, so it uses the held copy.
    assign al_f3  = (state == IDLE) ? req_funct3    : lat_req.funct3;
    assign al_off = (state == IDLE) ? req_addr[1:0] : lat_req.off;

    lsu_align #(.B_WIDTH(B_WIDTH)) u_align (
        .funct3   (al_f3),
        .addr_off (al_off),
        .wdata    (req_wdata),
        .rdata    (mem_rdata),
        .byte_en  (al_be),
        .st_data  (al_wdata),
        .ld_data  (al_ldata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = req_err ? RESP : ACCESS;
            ACCESS:  state_next = lat_req.is_store ? RESP : WAIT;
            WAIT:    if (wait_cnt == '0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output values for the state being entered
    always_comb begin
        resp_valid_d    = 1'b0;
        resp_rd_d       = '0;
        resp_data_d     = '0;
        resp_err_d      = 1'b0;
        mem_addr_d      = '0;
        mem_read_en_d   = 1'b0;
        mem_write_en_d  = 1'b0;
        write_byte_en_d = '0;
        mem_wdata_d     = '0;
        case (state)
            IDLE: begin
                if (state_next == ACCESS) begin
                    mem_addr_d = {req_addr[B_WIDTH-1:2], 2'b00};
                    if (req_is_store) begin
                        mem_write_en_d  = 1'b1;
                        write_byte_en_d = al_be;
                        mem_wdata_d     = al_wdata;
                    end else begin
                        mem_read_en_d = 1'b1;
                    end
                end else if (state_next == RESP) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end
            end
            ACCESS: begin
                if (state_next == WAIT) mem_addr_d   = mem_addr;
                else                    resp_valid_d = 1'b1;
            end
            WAIT: begin
                if (state_next == WAIT) begin
                    mem_addr_d = mem_addr;
                end else begin
                    // Last wait cycle: mem_rdata is valid now, capture it extracted.
                    resp_valid_d = 1'b1;
                    resp_rd_d    = lat_req.rd;
                    resp_data_d  = al_ldata;
                end
            end
            default: ;
        endcase
    end

    // Held request, wait counter and output flops
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_req       <= '0;
            wait_cnt      <= '0;
            resp_valid    <= 1'b0;
            resp_rd       <= '0;
            resp_data     <= '0;
            resp_err      <= 1'b0;
            mem_addr      <= '0;
            mem_read_en   <= 1'b0;
            mem_write_en  <= 1'b0;
            write_byte_en <= '0;
            mem_wdata     <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                lat_req.is_store <= req_is_store;
                lat_req.funct3   <= req_funct3;
                lat_req.off      <= req_addr[1:0];
                lat_req.rd       <= req_rd;
            end
            if (state == ACCESS)                         wait_cnt <= CW'(MEM_LATENCY - 1);
            else if (state == WAIT && wait_cnt != '0)    wait_cnt <= wait_cnt - CW'(1);
            resp_valid    <= resp_valid_d;
            resp_rd       <= resp_rd_d;
            resp_data     <= resp_data_d;
            resp_err      <= resp_err_d;
            mem_addr      <= mem_addr_d;
            mem_read_en   <= mem_read_en_d;
            mem_write_en  <= mem_write_en_d;
            write_byte_en <= write_byte_en_d;
            mem_wdata     <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_valid3 = 1'b0;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic [31:0] mem_rdata = '0, mem_rdata3 = '0;
    logic [31:0] mem_val = '0;

    logic        req_ready, resp_valid, resp_err, stall, mem_read_en, mem_write_en;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data, mem_addr, mem_wdata;
    logic [3:0]  write_byte_en;

    logic        req_ready3, resp_valid3, resp_err3, stall3, mem_read_en3, mem_write_en3;
    logic [4:0]  resp_rd3;
    logic [31:0] resp_data3, mem_addr3, mem_wdata3;
    logic [3:0]  write_byte_en3;

    int vec = 0, miss = 0, cyc = 0, acc_cyc = 0;
    bit armed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc++;
        if (rst) armed = 1;
    end

    lsu_ctrl #(.B_WIDTH(32), .MEM_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd), .resp_valid(resp_valid), .resp_rd(resp_rd),
        .resp_data(resp_data), .resp_err(resp_err), .stall(stall), .mem_addr(mem_addr),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .write_byte_en(write_byte_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    lsu_ctrl #(.B_WIDTH(32), .MEM_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_is_store(req_is_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd), .resp_valid(resp_valid3), .resp_rd(resp_rd3),
        .resp_data(resp_data3), .resp_err(resp_err3), .stall(stall3), .mem_addr(mem_addr3),
        .mem_read_en(mem_read_en3), .mem_write_en(mem_write_en3), .write_byte_en(write_byte_en3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
    );

    // Memory: read data is valid only in the cycle exactly LATENCY cycles after
    // the read strobe cycle; garbage otherwise.
    int d1 = -1, d3 = -1;
    always @(negedge clk) begin
        if (mem_read_en === 1'b1) d1 = 1; else if (d1 >= 0) d1--;
        mem_rdata = (d1 == 0) ? mem_val : 32'hBAD0_BAD0;
        if (mem_read_en3 === 1'b1) d3 = 3; else if (d3 >= 0) d3--;
        mem_rdata3 = (d3 == 0) ? mem_val : 32'hBAD0_BAD0;
    end

    // ---------------- behavioural model (main DUT, MEM_LATENCY=1) ----------------
    typedef struct packed {
        logic        ready, stall, rv, err;
        logic [4:0]  rd;
        logic [31:0] data, addr;
        logic        ren, wen;
        logic [3:0]  be;
        logic [31:0] wd;
    } snap_t;

    snap_t exp_q[$];

    function automatic bit req_bad(input bit st, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (!legal) return 1;
        if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) return 1;
        if (f3 == 3'd2 && (a % 4 != 0)) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] v);
        logic [31:0] b, h;
        b = (v >> (8 * (a % 4))) & 32'hFF;
        h = (v >> (8 * (a % 4))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            default: return v;
        endcase
    endfunction

    task automatic model_accept();
        snap_t s;
        logic [31:0] aw;
        aw = req_addr & 32'hFFFF_FFFC;
        if (req_bad(req_is_store, req_funct3, req_addr)) begin
            s = '0; s.stall = 1; s.rv = 1; s.err = 1; exp_q.push_back(s);
        end else if (req_is_store) begin
            s = '0; s.stall = 1; s.addr = aw; s.wen = 1;
            case (req_funct3)
                3'd0: begin s.be = 4'(1 << (req_addr % 4)); s.wd = (req_wdata & 32'hFF) * 32'h0101_0101; end
                3'd1: begin s.be = 4'(3 << (req_addr % 4)); s.wd = (req_wdata & 32'hFFFF) * 32'h0001_0001; end
                default: begin s.be = 4'hF; s.wd = req_wdata; end
            endcase
            exp_q.push_back(s);
            s = '0; s.stall = 1; s.rv = 1; exp_q.push_back(s);
        end else begin
            s = '0; s.stall = 1; s.addr = aw; s.ren = 1; exp_q.push_back(s);
            s = '0; s.stall = 1; s.addr = aw; exp_q.push_back(s);
            s = '0; s.stall = 1; s.rv = 1; s.rd = req_rd;
            s.data = load_val(req_funct3, req_addr, mem_val);
            exp_q.push_back(s);
        end
    endtask

    always @(negedge clk) begin
        snap_t e, a;
        bit idle;
        if (armed) begin
            idle = (exp_q.size() == 0);
            if (idle) begin e = '0; e.ready = 1; end
            else e = exp_q[0];
            a = '{req_ready, stall, resp_valid, resp_err, resp_rd, resp_data, mem_addr,
                  mem_read_en, mem_write_en, write_byte_en, mem_wdata};
            vec++;
            if (a !== e) begin
                miss++;
                $display("FAIL cycle %0d outputs: actual rdy=%b stl=%b rv=%b err=%b rd=%0d data=%h addr=%h ren=%b wen=%b be=%h wd=%h required rdy=%b stl=%b rv=%b err=%b rd=%0d data=%h addr=%h ren=%b wen=%b be=%h wd=%h",
                         cyc, a.ready, a.stall, a.rv, a.err, a.rd, a.data, a.addr, a.ren, a.wen, a.be, a.wd,
                         e.ready, e.stall, e.rv, e.err, e.rd, e.data, e.addr, e.ren, e.wen, e.be, e.wd);
            end
            if (!idle) void'(exp_q.pop_front());
            if (rst) exp_q.delete();
            else if (idle && req_valid) model_accept();
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic issue(input bit sel, input bit st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        bit ok = 0;
        req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
        if (sel) req_valid3 = 1'b1; else req_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if ((sel ? req_ready3 : req_ready) === 1'b1) ok = 1;
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        acc_cyc = cyc;
    endtask

    task automatic wait_resp(input bit sel, output int lat);
        lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(negedge clk);
            if ((sel ? resp_valid3 : resp_valid) === 1'b1) lat = i;
        end
    endtask

    typedef struct {
        bit          st;
        logic [2:0]  f3;
        logic [31:0] a, wd;
        logic [4:0]  rd;
        logic [31:0] mv;
        int          lat;
        bit          err;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] mwd, maddr;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int lat, a1, a2;
        tbl = '{
            '{1, 3'd2, 32'h104, 32'hDEADBEEF, 5'd7,  32'h0,        2, 0, 32'h0,        4'hF, 32'hDEADBEEF, 32'h104},
            '{1, 3'd0, 32'h103, 32'h000000A5, 5'd7,  32'h0,        2, 0, 32'h0,        4'h8, 32'hA5A5A5A5, 32'h100},
            '{1, 3'd1, 32'h102, 32'h1234BEEF, 5'd7,  32'h0,        2, 0, 32'h0,        4'hC, 32'hBEEFBEEF, 32'h100},
            '{0, 3'd0, 32'h102, 32'h0,        5'd5,  32'h12803456, 3, 0, 32'hFFFFFF80, 4'h0, 32'h0,        32'h100},
            '{0, 3'd4, 32'h102, 32'h0,        5'd6,  32'h12803456, 3, 0, 32'h00000080, 4'h0, 32'h0,        32'h100},
            '{0, 3'd1, 32'h102, 32'h0,        5'd9,  32'h80001234, 3, 0, 32'hFFFF8000, 4'h0, 32'h0,        32'h100},
            '{0, 3'd5, 32'h102, 32'h0,        5'd10, 32'h80001234, 3, 0, 32'h00008000, 4'h0, 32'h0,        32'h100},
            '{0, 3'd2, 32'h108, 32'h0,        5'd31, 32'hCAFEF00D, 3, 0, 32'hCAFEF00D, 4'h0, 32'h0,        32'h108},
            '{0, 3'd0, 32'h101, 32'h0,        5'd3,  32'h12803456, 3, 0, 32'h00000034, 4'h0, 32'h0,        32'h100},
            '{0, 3'd1, 32'h101, 32'h0,        5'd4,  32'h0,        1, 1, 32'h0,        4'h0, 32'h0,        32'h0},
            '{1, 3'd2, 32'h106, 32'h11223344, 5'd0,  32'h0,        1, 1, 32'h0,        4'h0, 32'h0,        32'h0},
            '{1, 3'd4, 32'h100, 32'h11223344, 5'd0,  32'h0,        1, 1, 32'h0,        4'h0, 32'h0,        32'h0},
            '{0, 3'd3, 32'h100, 32'h0,        5'd2,  32'h0,        1, 1, 32'h0,        4'h0, 32'h0,        32'h0}
        };

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready",   {31'd0, req_ready}, 32'd1);
        chk("rst_stall",   {31'd0, stall}, 32'd0);
        chk("rst_strobes", {29'd0, resp_valid, mem_read_en, mem_write_en}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);

        foreach (tbl[i]) begin
            mem_val = tbl[i].mv;
            issue(0, tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].rd);
            req_valid = 1'b0;
            chk($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].maddr);
            chk($sformatf("v%0d_byte_en", i), {28'd0, write_byte_en}, {28'd0, tbl[i].be});
            chk($sformatf("v%0d_mem_wdata", i), mem_wdata, tbl[i].mwd);
            chk($sformatf("v%0d_ren_wen", i), {30'd0, mem_read_en, mem_write_en},
                {30'd0, !tbl[i].st && !tbl[i].err, tbl[i].st && !tbl[i].err});
            wait_resp(0, lat);
            chk($sformatf("v%0d_latency", i), lat, tbl[i].lat);
            chk($sformatf("v%0d_resp_err", i), {31'd0, resp_err}, {31'd0, tbl[i].err});
            chk($sformatf("v%0d_resp_data", i), resp_data, tbl[i].data);
            chk($sformatf("v%0d_resp_rd", i), {27'd0, resp_rd},
                (tbl[i].st || tbl[i].err) ? 32'd0 : {27'd0, tbl[i].rd});
        end

        // Back-to-back: req_valid never drops between the two stores.
        issue(0, 1, 3'd2, 32'h200, 32'h0BADF00D, 5'd1);
        a1 = acc_cyc;
        issue(0, 1, 3'd2, 32'h204, 32'h600DCAFE, 5'd1);
        a2 = acc_cyc;
        req_valid = 1'b0;
        chk("b2b_accept_gap", a2 - a1, 32'd3);
        chk("b2b_second_wdata", mem_wdata, 32'h600DCAFE);
        wait_resp(0, lat);
        chk("b2b_second_latency", lat, 32'd2);

        // Reset while the load sits in WAIT.
        mem_val = 32'h55AA55AA;
        issue(0, 0, 3'd2, 32'h300, 32'h0, 5'd12);
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_in_wait", {30'd0, stall, mem_read_en}, 32'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_wait_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_wait_strobes", {26'd0, mem_read_en, mem_write_en, write_byte_en}, 32'd0);
        chk("rst_wait_mem_addr", mem_addr, 32'd0);
        wait_resp(0, lat);
        chk("rst_wait_no_resp", lat, -32'sd1);

        // MEM_LATENCY=3 instance: load completes 5 cycles after accept.
        mem_val = 32'h12803456;
        issue(1, 0, 3'd0, 32'h102, 32'h0, 5'd8);
        req_valid3 = 1'b0;
        wait_resp(1, lat);
        chk("l3_latency", lat, 32'd5);
        chk("l3_resp_data", resp_data3, 32'hFFFFFF80);
        chk("l3_resp_rd", {27'd0, resp_rd3}, 32'd8);
        chk("l3_resp_err", {31'd0, resp_err3}, 32'd0);
        @(negedge clk);
        chk("l3_idle_ctrl", {22'd0, req_ready3, stall3, resp_valid3, mem_read_en3, mem_write_en3,
                             write_byte_en3, 1'b0}, 32'h200);
        chk("l3_idle_bus", mem_addr3 | mem_wdata3, 32'd0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
